// File: rtl/phase_slot_scheduler_if.sv
// phase_slot_scheduler_if
//   Groups the requester-facing signals of the four-phase slot scheduler.
//   Handshake: a requester raises Req[i] and holds it while it wants the
//   resource; it owns the resource while Grant[i]=1 and ends its slot by
//   pulsing Done[i] (or by dropping Req[i]). Done[i] means nothing unless
//   Grant[i]=1 in the same cycle.
//   Signals:
//     Enable   scheduler run enable
//     Req      per-phase request (bit i = phase i)
//     Done     per-phase completion, qualified by Grant
//     Phase    one-hot phase pointer
//     Grant    one-hot or zero grant, equal to Phase when non-zero
//     Busy     scheduler not idle
//     Timeout  single-cycle forced-release pulse
//     SlotCnt  cycles elapsed in the current grant
//   Modports: master = requester side, slave = scheduler side.
interface phase_slot_scheduler_if #(
  parameter int CNT_W = 4
);
  logic             Enable;
  logic [3:0]       Req;
  logic [3:0]       Done;
  logic [3:0]       Phase;
  logic [3:0]       Grant;
  logic             Busy;
  logic             Timeout;
  logic [CNT_W-1:0] SlotCnt;

  modport master (
    output Enable, Req, Done,
    input  Phase, Grant, Busy, Timeout, SlotCnt
  );

  modport slave (
    input  Enable, Req, Done,
    output Phase, Grant, Busy, Timeout, SlotCnt
  );
endinterface

// File: rtl/phase_slot_scheduler.sv
// phase_slot_scheduler
//   Shares one resource among four requesters, one per phase of a one-hot
//   ring (0001 -> 0010 -> 0100 -> 1000 -> 0001). The ring advances only when
//   a slot ends, so a grant lasts from one cycle up to SLOT_MAX cycles,
//   followed by one guard cycle with no owner.
//   Optional build macro PHASE_SKIP_EN: in SCAN the pointer jumps straight to
//   the next requesting phase and grants it on the same edge; with no
//   requests the pointer holds instead of free-running.
//   Ports:
//     Phase_Count  clock, rising edge
//     invClear     asynchronous active-low reset
//     bus          phase_slot_scheduler_if.slave (Enable/Req/Done in,
//                  Phase/Grant/Busy/Timeout/SlotCnt out)
//     state_o      current FSM state for debug/observation
module phase_slot_scheduler #(
  parameter int SLOT_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic                          Phase_Count,
  input  logic                          invClear,
  phase_slot_scheduler_if.slave         bus,
  output logic [1:0]                    state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_MAX - 1);

  state_e           state_q, state_d;
  logic [3:0]       phase_q, phase_d;
  logic [3:0]       grant_q, grant_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             timeout_c;
  logic             req_cur;
  logic             done_cur;

  function automatic logic [3:0] rotl(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

`ifdef PHASE_SKIP_EN
  // First requesting phase strictly after the current one in ring order.
  // Only meaningful when some Req bit outside the current phase is set.
  function automatic logic [3:0] next_req_after(input logic [3:0] cur,
                                                input logic [3:0] req);
    logic [3:0] p;
    logic [3:0] res;
    logic       found;
    p     = cur;
    res   = cur;
    found = 1'b0;
    for (int k = 0; k < 3; k++) begin
      p = rotl(p);
      if (!found && (|(p & req))) begin
        res   = p;
        found = 1'b1;
      end
    end
    return res;
  endfunction
`endif

  // Request/done of the phase the pointer currently selects.
  assign req_cur  = |(bus.Req  & phase_q);
  assign done_cur = |(bus.Done & phase_q);

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    timeout_c = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d = 4'b0000;
        if (bus.Enable) state_d = SCAN;
      end
      SCAN: begin
        if (!bus.Enable) begin
          state_d = IDLE;
        end else if (req_cur) begin
          state_d = GRANT;
          grant_d = phase_q;
          cnt_d   = '0;
        end else begin
`ifdef PHASE_SKIP_EN
          if (|bus.Req) begin
            state_d = GRANT;
            phase_d = next_req_after(phase_q, bus.Req);
            grant_d = next_req_after(phase_q, bus.Req);
            cnt_d   = '0;
          end
`else
          phase_d = rotl(phase_q);
`endif
        end
      end
      GRANT: begin
        // Enable is deliberately not looked at: a live grant always ends
        // through Done, a Req drop or the slot limit.
        cnt_d = (cnt_q == SLOT_LAST) ? cnt_q : cnt_q + CNT_W'(1);
        if (done_cur) begin
          state_d = RELEASE;
          grant_d = 4'b0000;
        end else if (!req_cur) begin
          state_d = RELEASE;
          grant_d = 4'b0000;
        end else if (cnt_q == SLOT_LAST) begin
          // Done has priority above, so Timeout only fires on a true overrun.
          state_d   = RELEASE;
          grant_d   = 4'b0000;
          timeout_c = 1'b1;
        end
      end
      RELEASE: begin
        grant_d = 4'b0000;
        phase_d = rotl(phase_q);
        cnt_d   = '0;
        state_d = bus.Enable ? SCAN : IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge Phase_Count or negedge invClear) begin
    if (!invClear) begin
      state_q <= IDLE;
      phase_q <= 4'b0001;
      grant_q <= 4'b0000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.Phase   = phase_q;
  assign bus.Grant   = grant_q;
  assign bus.Busy    = (state_q != IDLE);
  assign bus.Timeout = timeout_c;
  assign bus.SlotCnt = cnt_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_phase_slot_scheduler.sv
module tb_phase_slot_scheduler;

  localparam int W = 15;

  logic clk;
  logic inv_clear;
  logic [1:0] state_dbg;

  int n_total;
  int n_bad;
  string cur_tag;

  // Expected entry: {cnt_chk, grant[3:0], phase[3:0], cnt[3:0], timeout, busy}
  logic [W-1:0] exp_q[$];

  phase_slot_scheduler_if #(.CNT_W(4)) bus ();

  phase_slot_scheduler #(.SLOT_MAX(15), .CNT_W(4)) dut (
    .Phase_Count (clk),
    .invClear    (inv_clear),
    .bus         (bus),
    .state_o     (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish by 200000");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s/%s: got %0h want %0h at %0t", cur_tag, tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ex(input logic [3:0] g, input logic [3:0] p,
                                      input int cnt, input logic chk,
                                      input logic to, input logic busy);
    logic [3:0] c;
    c = 4'(cnt);
    return {chk, g, p, c, to, busy};
  endfunction

  function automatic logic [3:0] rotl(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  // Scoreboard: one expected entry per cycle, compared mid-cycle.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("grant",   32'(bus.Grant),   32'(e[13:10]));
      check("phase",   32'(bus.Phase),   32'(e[9:6]));
      check("timeout", 32'(bus.Timeout), 32'(e[1]));
      check("busy",    32'(bus.Busy),    32'(e[0]));
      if (e[14]) check("slotcnt", 32'(bus.SlotCnt), 32'(e[5:2]));
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1: drives this cycle's inputs and queues the outputs
  // expected during this cycle, then advances to the next posedge+1.
  task automatic drive_cycle(input logic en, input logic [3:0] req,
                             input logic [3:0] done, input logic [W-1:0] e);
    bus.Enable = en;
    bus.Req    = req;
    bus.Done   = done;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cur_tag   = "reset";
    inv_clear = 1'b0;
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 4'h0, 4'h0, ex(4'h0, 4'h1, 0, 1'b1, 1'b0, 1'b0));
    inv_clear = 1'b1;
    for (int i = 0; i < 2; i++) drive_cycle(1'b0, 4'h0, 4'h0, ex(4'h0, 4'h1, 0, 1'b1, 1'b0, 1'b0));
  endtask

  // From IDLE at phase 0001 up to the edge that grants phase t.
  task automatic to_grant(input int t);
    logic [3:0] tp;
    tp = 4'(1 << t);
    drive_cycle(1'b1, tp, 4'h0, ex(4'h0, 4'h1, 0, 1'b1, 1'b0, 1'b0));
`ifdef PHASE_SKIP_EN
    drive_cycle(1'b1, tp, 4'h0, ex(4'h0, 4'h1, 0, 1'b1, 1'b0, 1'b1));
`else
    for (int p = 0; p <= t; p++)
      drive_cycle(1'b1, tp, 4'h0, ex(4'h0, 4'(1 << p), 0, 1'b1, 1'b0, 1'b1));
`endif
  endtask

  // how: 0 = Done at end_cnt, 1 = Req drop at end_cnt, 2 = no end (timeout).
  task automatic slot_run(input int t, input int end_cnt, input int how);
    logic [3:0] tp;
    logic [3:0] r;
    logic [3:0] d;
    tp = 4'(1 << t);
    cur_tag = $sformatf("slot_p%0d_e%0d_h%0d", t, end_cnt, how);
    to_grant(t);
    for (int k = 0; k <= end_cnt; k++) begin
      r = tp;
      d = ~tp;  // done bits of other phases must be ignored
      if (k == end_cnt) begin
        if (how == 0) d = 4'hf;
        else if (how == 1) r = 4'h0;
      end
      drive_cycle(1'b1, r, d, ex(tp, tp, k, 1'b1, (how == 2) && (k == 14), 1'b1));
    end
    drive_cycle(1'b0, 4'h0, 4'h0, ex(4'h0, tp, 0, 1'b0, 1'b0, 1'b1));
    drive_cycle(1'b0, 4'h0, 4'h0, ex(4'h0, rotl(tp), 0, 1'b1, 1'b0, 1'b0));
  endtask

  task automatic rotation();
    logic [3:0] ph;
    cur_tag = "rotation";
    drive_cycle(1'b1, 4'hf, 4'hf, ex(4'h0, 4'h1, 0, 1'b1, 1'b0, 1'b0));
    for (int lap = 0; lap < 2; lap++) begin
      for (int p = 0; p < 4; p++) begin
        ph = 4'(1 << p);
        drive_cycle(1'b1, 4'hf, 4'hf, ex(4'h0, ph, 0, 1'b1, 1'b0, 1'b1));
        drive_cycle(1'b1, 4'hf, 4'hf, ex(ph,   ph, 0, 1'b1, 1'b0, 1'b1));
        drive_cycle(1'b1, 4'hf, 4'hf, ex(4'h0, ph, 0, 1'b0, 1'b0, 1'b1));
      end
    end
    drive_cycle(1'b0, 4'hf, 4'hf, ex(4'h0, 4'h1, 0, 1'b1, 1'b0, 1'b1));
    drive_cycle(1'b0, 4'h0, 4'h0, ex(4'h0, 4'h1, 0, 1'b1, 1'b0, 1'b0));
  endtask

  task automatic reset_mid_grant();
    cur_tag = "rst_mid";
    to_grant(1);
    drive_cycle(1'b1, 4'h2, 4'h0, ex(4'h2, 4'h2, 0, 1'b1, 1'b0, 1'b1));
    // Now inside the second grant cycle; pull reset between edges.
    #2;
    inv_clear = 1'b0;
    #1;
    check("async_grant", 32'(bus.Grant),   32'h0);
    check("async_phase", 32'(bus.Phase),   32'h1);
    check("async_busy",  32'(bus.Busy),    32'h0);
    check("async_cnt",   32'(bus.SlotCnt), 32'h0);
    bus.Req = 4'h0;
    @(posedge clk);
    #1;
    inv_clear = 1'b1;
    slot_run(1, 0, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_total   = 0;
    n_bad     = 0;
    cur_tag   = "init";
    inv_clear = 1'b0;
    bus.Enable = 1'b0;
    bus.Req    = 4'h0;
    bus.Done   = 4'h0;
    @(posedge clk);
    #1;
    do_reset();
    slot_run(0, 3, 0);   // single slot, Done on 4th grant cycle
    do_reset();
    rotation();
    do_reset();
    slot_run(2, 14, 2);  // overrun -> Timeout on SlotCnt=14
    do_reset();
    slot_run(1, 14, 0);  // Done on the limit cycle wins over Timeout
    do_reset();
    slot_run(1, 2, 1);   // Req drop = early finish
    do_reset();
    slot_run(3, 0, 0);   // idle-phase stepping
    do_reset();
    // Random short slots on random phases.
    for (int i = 0; i < 4; i++) begin
      slot_run(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)), int'($urandom_range(0, 1)));
      do_reset();
    end
    reset_mid_grant();
    @(negedge clk);
    cur_tag = "end";
    check("drain", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
